// File: rtl/skin_box_if.sv
// Video stream and box-coordinate bundle between the skin threshold stage,
// the box locator and the downstream video encoder.
interface skin_box_if #(
    parameter int IMG_WIDTH_DATA = 24,
    parameter int CNT_W          = 12
);
    logic [IMG_WIDTH_DATA-1:0] i_binary;
    logic [IMG_WIDTH_DATA-1:0] i_rgb;
    logic                      i_hsync;
    logic                      i_vsync;
    logic                      i_de;
    logic [IMG_WIDTH_DATA-1:0] o_rgb;
    logic                      o_hsync;
    logic                      o_vsync;
    logic                      o_de;
    logic                      box_valid;
    logic [CNT_W-1:0]          box_x_min;
    logic [CNT_W-1:0]          box_x_max;
    logic [CNT_W-1:0]          box_y_min;
    logic [CNT_W-1:0]          box_y_max;

    modport master (
        output i_binary, i_rgb, i_hsync, i_vsync, i_de,
        input  o_rgb, o_hsync, o_vsync, o_de,
        input  box_valid, box_x_min, box_x_max, box_y_min, box_y_max
    );

    modport slave (
        input  i_binary, i_rgb, i_hsync, i_vsync, i_de,
        output o_rgb, o_hsync, o_vsync, o_de,
        output box_valid, box_x_min, box_x_max, box_y_min, box_y_max
    );
endinterface

// File: rtl/skin_box_locator.sv
// Finds the bounding box of skin pixels per frame, latches it at vsync rise
// and draws it as a one-pixel rectangle over the following frame's RGB.
module skin_box_locator #(
    parameter int                        IMG_WIDTH_DATA = 24,
    parameter int                        CNT_W          = 12,
    parameter int                        MIN_PIXELS     = 16,
    parameter logic [IMG_WIDTH_DATA-1:0] BOX_COLOR      = 24'hFF0000
) (
    input  logic         pixelclk,
    input  logic         reset,
    skin_box_if.slave    vid
);
    localparam logic [2*CNT_W-1:0] MIN_CNT = (2*CNT_W)'(MIN_PIXELS);
    localparam logic [CNT_W-1:0]   ONE_C   = CNT_W'(1);
    localparam logic [2*CNT_W-1:0] ONE_R   = (2*CNT_W)'(1);

    logic [CNT_W-1:0]          x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic                      de_q, vs_q;
    logic [CNT_W-1:0]          run_x_min_q, run_x_min_d, run_x_max_q, run_x_max_d;
    logic [CNT_W-1:0]          run_y_min_q, run_y_min_d, run_y_max_q, run_y_max_d;
    logic [2*CNT_W-1:0]        run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]          box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
    logic [CNT_W-1:0]          box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
    logic                      box_valid_q, box_valid_d;
    logic [IMG_WIDTH_DATA-1:0] o_rgb_q, o_rgb_d;
    logic                      o_hsync_q, o_vsync_q, o_de_q;

    logic                      vs_rise_s, skin_s, border_s;
    logic                      in_x_s, in_y_s, on_x_s, on_y_s;
    logic [CNT_W-1:0]          y_cur_s;
    logic [CNT_W-1:0]          base_x_min_s, base_x_max_s, base_y_min_s, base_y_max_s;
    logic [2*CNT_W-1:0]        base_cnt_s;

    // Next-state for counters, frame accumulation, box latch and overlay.
    always_comb begin
        vs_rise_s = vid.i_vsync & ~vs_q;
        skin_s    = vid.i_de & (vid.i_binary == '0);
        // A pixel coincident with the vsync rise belongs to row 0 of the new frame.
        y_cur_s   = vs_rise_s ? '0 : y_cnt_q;

        x_cnt_d = vid.i_de ? ((x_cnt_q == '1) ? x_cnt_q : x_cnt_q + ONE_C) : '0;
        if (vs_rise_s) begin
            y_cnt_d = '0;
        end else if (de_q & ~vid.i_de) begin
            y_cnt_d = (y_cnt_q == '1) ? y_cnt_q : y_cnt_q + ONE_C;
        end else begin
            y_cnt_d = y_cnt_q;
        end

        box_x_min_d = box_x_min_q;
        box_x_max_d = box_x_max_q;
        box_y_min_d = box_y_min_q;
        box_y_max_d = box_y_max_q;
        box_valid_d = box_valid_q;
        if (vs_rise_s) begin
            if (run_cnt_q >= MIN_CNT) begin
                box_x_min_d = run_x_min_q;
                box_x_max_d = run_x_max_q;
                box_y_min_d = run_y_min_q;
                box_y_max_d = run_y_max_q;
                box_valid_d = 1'b1;
            end else begin
                box_valid_d = 1'b0;
            end
            base_x_min_s = '1;
            base_x_max_s = '0;
            base_y_min_s = '1;
            base_y_max_s = '0;
            base_cnt_s   = '0;
        end else begin
            base_x_min_s = run_x_min_q;
            base_x_max_s = run_x_max_q;
            base_y_min_s = run_y_min_q;
            base_y_max_s = run_y_max_q;
            base_cnt_s   = run_cnt_q;
        end

        if (skin_s) begin
            run_x_min_d = (x_cnt_q < base_x_min_s) ? x_cnt_q : base_x_min_s;
            run_x_max_d = (x_cnt_q > base_x_max_s) ? x_cnt_q : base_x_max_s;
            run_y_min_d = (y_cur_s < base_y_min_s) ? y_cur_s : base_y_min_s;
            run_y_max_d = (y_cur_s > base_y_max_s) ? y_cur_s : base_y_max_s;
            run_cnt_d   = (base_cnt_s == '1) ? base_cnt_s : base_cnt_s + ONE_R;
        end else begin
            run_x_min_d = base_x_min_s;
            run_x_max_d = base_x_max_s;
            run_y_min_d = base_y_min_s;
            run_y_max_d = base_y_max_s;
            run_cnt_d   = base_cnt_s;
        end

        // Overlay uses the box as registered now, never the one being latched.
        in_x_s   = (x_cnt_q >= box_x_min_q) & (x_cnt_q <= box_x_max_q);
        in_y_s   = (y_cur_s >= box_y_min_q) & (y_cur_s <= box_y_max_q);
        on_x_s   = (x_cnt_q == box_x_min_q) | (x_cnt_q == box_x_max_q);
        on_y_s   = (y_cur_s == box_y_min_q) | (y_cur_s == box_y_max_q);
        border_s = box_valid_q & vid.i_de & ((on_x_s & in_y_s) | (on_y_s & in_x_s));
        o_rgb_d  = border_s ? BOX_COLOR : vid.i_rgb;
    end

    // State and registered outputs.
    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            de_q        <= 1'b0;
            vs_q        <= 1'b0;
            run_x_min_q <= '1;
            run_x_max_q <= '0;
            run_y_min_q <= '1;
            run_y_max_q <= '0;
            run_cnt_q   <= '0;
            box_x_min_q <= '0;
            box_x_max_q <= '0;
            box_y_min_q <= '0;
            box_y_max_q <= '0;
            box_valid_q <= 1'b0;
            o_rgb_q     <= '0;
            o_hsync_q   <= 1'b0;
            o_vsync_q   <= 1'b0;
            o_de_q      <= 1'b0;
        end else begin
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            de_q        <= vid.i_de;
            vs_q        <= vid.i_vsync;
            run_x_min_q <= run_x_min_d;
            run_x_max_q <= run_x_max_d;
            run_y_min_q <= run_y_min_d;
            run_y_max_q <= run_y_max_d;
            run_cnt_q   <= run_cnt_d;
            box_x_min_q <= box_x_min_d;
            box_x_max_q <= box_x_max_d;
            box_y_min_q <= box_y_min_d;
            box_y_max_q <= box_y_max_d;
            box_valid_q <= box_valid_d;
            o_rgb_q     <= o_rgb_d;
            o_hsync_q   <= vid.i_hsync;
            o_vsync_q   <= vid.i_vsync;
            o_de_q      <= vid.i_de;
        end
    end

    assign vid.o_rgb     = o_rgb_q;
    assign vid.o_hsync   = o_hsync_q;
    assign vid.o_vsync   = o_vsync_q;
    assign vid.o_de      = o_de_q;
    assign vid.box_valid = box_valid_q;
    assign vid.box_x_min = box_x_min_q;
    assign vid.box_x_max = box_x_max_q;
    assign vid.box_y_min = box_y_min_q;
    assign vid.box_y_max = box_y_max_q;
endmodule

// File: tb/tb_skin_box_locator.sv
// Directed bench for skin_box_locator: 8x4 frames with hand-placed skin pixels.
module tb_skin_box_locator;
    localparam logic [23:0] BG  = 24'hFFFFFF;
    localparam logic [23:0] RED = 24'hFF0000;

    logic pixelclk = 1'b0;
    logic reset    = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [23:0] obs_rgb [32];

    skin_box_if #(.IMG_WIDTH_DATA(24), .CNT_W(12)) bus ();

    skin_box_locator #(
        .IMG_WIDTH_DATA(24),
        .CNT_W(12),
        .MIN_PIXELS(2),
        .BOX_COLOR(24'hFF0000)
    ) dut (
        .pixelclk(pixelclk),
        .reset(reset),
        .vid(bus.slave)
    );

    always #5 pixelclk = ~pixelclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [23:0] bin, input logic [23:0] rgb,
                        input logic hs, input logic vs, input logic de);
        bus.i_binary = bin;
        bus.i_rgb    = rgb;
        bus.i_hsync  = hs;
        bus.i_vsync  = vs;
        bus.i_de     = de;
        @(posedge pixelclk);
        #1;
    endtask

    // 4 active lines of 8 pixels; mask bit y*8+x marks a skin pixel.
    task automatic frame_lines(input logic [31:0] mask, input logic [23:0] rgb);
        step(BG, 24'h0, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                step(mask[r*8+c] ? 24'h0 : BG, rgb, 1'b0, 1'b0, 1'b1);
                obs_rgb[r*8+c] = bus.o_rgb;
            end
            step(BG, 24'h0, 1'b1, 1'b0, 1'b0);
            step(BG, 24'h0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic check_box(input string tag, input logic v, input logic [11:0] x0,
                             input logic [11:0] x1, input logic [11:0] y0, input logic [11:0] y1);
        check_eq({tag, "_valid"}, bus.box_valid, v);
        check_eq({tag, "_xmin"}, bus.box_x_min, x0);
        check_eq({tag, "_xmax"}, bus.box_x_max, x1);
        check_eq({tag, "_ymin"}, bus.box_y_min, y0);
        check_eq({tag, "_ymax"}, bus.box_y_max, y1);
    endtask

    initial begin
        logic [23:0] rgb_r, bin_r;
        logic        hs_r, vs_r, de_r;

        bus.i_binary = 24'h0;
        bus.i_rgb    = 24'h777777;
        bus.i_hsync  = 1'b1;
        bus.i_vsync  = 1'b1;
        bus.i_de     = 1'b1;
        repeat (2) @(posedge pixelclk);
        #1;
        check_eq("rst_rgb", bus.o_rgb, 24'h0);
        check_eq("rst_sync", {bus.o_hsync, bus.o_vsync, bus.o_de}, 3'b000);
        check_box("rst_box", 1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
        step(BG, 24'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Frame A: skin at (2,1) and (5,3).
        step(BG, 24'h0, 1'b0, 1'b1, 1'b0);
        check_eq("empty_latch_valid", bus.box_valid, 1'b0);
        step(BG, 24'h0, 1'b0, 1'b1, 1'b0);
        frame_lines(32'h1 << 10 | 32'h1 << 29, 24'h0);
        step(BG, 24'h0, 1'b0, 1'b1, 1'b0);
        check_box("boxA", 1'b1, 12'd2, 12'd5, 12'd1, 12'd3);
        step(BG, 24'h0, 1'b0, 1'b1, 1'b0);

        // Frame B: overlay of box A, single skin pixel at (7,0).
        frame_lines(32'h1 << 7, 24'h123456);
        check_eq("ovl_2_2", obs_rgb[18], RED);
        check_eq("ovl_3_2", obs_rgb[19], 24'h123456);
        check_eq("ovl_6_1", obs_rgb[14], 24'h123456);
        check_eq("ovl_2_1", obs_rgb[10], RED);
        check_eq("ovl_5_3", obs_rgb[29], RED);
        check_eq("ovl_4_3", obs_rgb[28], RED);
        check_eq("ovl_1_3", obs_rgb[25], 24'h123456);
        step(BG, 24'h0, 1'b0, 1'b1, 1'b0);
        check_box("few", 1'b0, 12'd2, 12'd5, 12'd1, 12'd3);
        step(BG, 24'h0, 1'b0, 1'b1, 1'b0);

        // Frame C: one skin pixel at (1,2), then a skin pixel on the vsync rise at x=3.
        frame_lines(32'h1 << 17, 24'hABCDEF);
        check_eq("no_ovl_invalid", obs_rgb[10], 24'hABCDEF);
        for (int i = 0; i < 3; i++) step(BG, 24'hABCDEF, 1'b0, 1'b0, 1'b1);
        step(24'h0, 24'hABCDEF, 1'b0, 1'b1, 1'b1);
        check_box("coinc", 1'b0, 12'd2, 12'd5, 12'd1, 12'd3);
        step(BG, 24'h0, 1'b0, 1'b1, 1'b0);
        step(BG, 24'h0, 1'b0, 1'b0, 1'b0);

        // Frame D: rows shifted to y=1..4, skin at (6,2); box must include (3,0).
        frame_lines(32'h1 << 14, 24'h0);
        step(BG, 24'h0, 1'b0, 1'b1, 1'b0);
        check_box("boxD", 1'b1, 12'd3, 12'd6, 12'd0, 12'd2);
        step(BG, 24'h0, 1'b0, 1'b1, 1'b0);
        step(BG, 24'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-line with skin pixels active.
        for (int i = 0; i < 3; i++) step(24'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        check_eq("pre_rst_de", bus.o_de, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_de", bus.o_de, 1'b0);
        check_box("async_rst", 1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
        bus.i_de     = 1'b0;
        bus.i_binary = BG;
        #2 reset = 1'b0;
        @(posedge pixelclk);
        #1;
        step(BG, 24'h5A5A5A, 1'b1, 1'b0, 1'b1);
        check_eq("post_rst_sync", {bus.o_hsync, bus.o_vsync, bus.o_de}, 3'b101);
        check_eq("post_rst_rgb", bus.o_rgb, 24'h5A5A5A);
        step(24'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        step(BG, 24'h0, 1'b0, 1'b0, 1'b1);
        step(BG, 24'h0, 1'b0, 1'b0, 1'b1);
        step(24'h0, 24'h0, 1'b0, 1'b0, 1'b1);
        step(BG, 24'h0, 1'b0, 1'b0, 1'b0);
        step(BG, 24'h0, 1'b0, 1'b1, 1'b0);
        check_box("after_rst", 1'b1, 12'd1, 12'd4, 12'd0, 12'd0);
        step(BG, 24'h0, 1'b0, 1'b0, 1'b0);

        // No-skin frame clears validity, then random sync patterns.
        step(BG, 24'h0, 1'b0, 1'b1, 1'b0);
        check_eq("noskin_valid", bus.box_valid, 1'b0);
        for (int i = 0; i < 80; i++) begin
            hs_r  = 1'($urandom_range(0, 1));
            vs_r  = 1'($urandom_range(0, 1));
            de_r  = 1'($urandom_range(0, 1));
            rgb_r = 24'($urandom);
            bin_r = 24'($urandom) | 24'h000001;
            step(bin_r, rgb_r, hs_r, vs_r, de_r);
            check_eq("rand_sync", {bus.o_hsync, bus.o_vsync, bus.o_de}, {hs_r, vs_r, de_r});
            check_eq("rand_rgb", bus.o_rgb, rgb_r);
        end
        check_eq("rand_valid", bus.box_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
